sc_matrix_decoder: RTL and testbench
====================================

Name: sc_matrix_decoder

Overview:
- Converts the NUM_STREAMS stochastic output bitstreams of the stochastic matrix-multiply array back into binary counts.
- Counts the ones on every stream over a fixed window of 2^LEN_LOG2 valid samples.
- Presents all counts at once on a valid/ready output port.
- Sits between the matrix-multiply output (BATCH_SIZE*OUTPUT_FEATURES streams) and binary downstream logic.

Parameters:
- NUM_STREAMS, 16, number of parallel bitstreams (BATCH_SIZE*OUTPUT_FEATURES).
- LEN_LOG2, 8, log2 of window length; window = 2^LEN_LOG2 valid samples.
- CW (localparam), LEN_LOG2+1, per-stream count width; holds 0..2^LEN_LOG2 inclusive.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  pulse to begin a new window.
- in_valid  input  1  streams_in carries a valid sample this cycle.
- streams_in  input  NUM_STREAMS  one bit per stream; bit k is stream k.
- busy  output  1  high while in ACCUM.
- out_valid  output  1  result held on out_data.
- out_ready  input  1  downstream accepts the result.
- out_data  output  NUM_STREAMS*CW  count for stream k at [k*CW +: CW].

Behaviour:
- Reset (rst=0, async): state=IDLE; all counters, sample counter and out_data = 0; busy=0; out_valid=0.
- FSM has three states: IDLE, ACCUM, HOLD.
- IDLE:
  - start=1 -> ACCUM.
  - Per-stream counters and sample counter clear to 0 on that edge.
  - in_valid/streams_in on the start cycle are ignored.
- ACCUM:
  - Each cycle with in_valid=1: counter[k] += streams_in[k] for every k; sample counter += 1.
  - in_valid=0: nothing changes (stall); no timeout.
  - start is ignored.
- Window end:
  - The cycle accepting sample number 2^LEN_LOG2 (sample counter == 2^LEN_LOG2-1 and in_valid=1) includes that sample's bits in the counts.
  - On that edge, final counts are latched into out_data; state -> HOLD; out_valid=1 from the next cycle.
  - Latency from last valid sample to out_valid = 1 cycle.
  - Minimum start-to-out_valid = 2^LEN_LOG2+1 cycles.
- HOLD:
  - out_valid=1; out_data stable until the handshake.
  - Handshake = out_valid & out_ready.
  - On handshake with start=0 -> IDLE; out_valid=0 next cycle. out_data keeps its last value (don't-care).
  - On handshake with start=1 in the same cycle -> ACCUM directly; counters clear. This gives back-to-back windows with no IDLE bubble.
  - start without a handshake is ignored.
- busy=1 exactly in ACCUM.
- Arithmetic: unsigned; counters never overflow because CW bits hold 2^LEN_LOG2. The sample counter is LEN_LOG2 bits and wraps only at the window end.
- Reset mid-window or mid-HOLD: partial counts are discarded, out_valid drops immediately (async), and no result is emitted.
- Samples arriving in IDLE or HOLD are dropped; the upstream must hold off until busy=1.

Optional Feature:
- Macro SC_DECODE_BIPOLAR_EN.
- Defined:
  - out_data holds the bipolar value v[k] = 2*count[k] - 2^LEN_LOG2 as two's complement.
  - CW becomes LEN_LOG2+2; range -2^LEN_LOG2..+2^LEN_LOG2.
  - Conversion happens at the latch into out_data; latency is unchanged.
- Undefined: unsigned counts, CW = LEN_LOG2+1 as above.
- FSM and handshake are identical in both builds.

Test Plan (NUM_STREAMS=4, LEN_LOG2=4, window 16):
1. Reset, start, 16 consecutive in_valid cycles with streams_in=4'b1111 -> out_valid on the cycle after the 16th sample; every count = 16 (5'b10000). Hold out_ready=0 for 5 cycles -> out_data stable; out_ready=1 -> out_valid=0 next cycle, busy=0.
2. streams_in: bit0 always 0, bit1 alternates 1/0, bit2 is 1 for 4 of 16 samples, bit3 always 1 -> counts {16, 4, 8, 0} for k={3,2,1,0}.
3. 16 valid samples interleaved with 10 in_valid=0 cycles and spurious start pulses mid-window -> same counts as with no gaps; out_valid asserts one cycle after the 16th valid sample, not earlier.
4. HOLD with out_ready=1 and start=1 on the same cycle -> busy=1 next cycle, no IDLE cycle. The second window of all-zero input yields counts 0.
5. Assert rst=0 after 9 samples of all-ones, release, start, feed 16 zeros -> counts 0; no out_valid before the new window completes.
6. With SC_DECODE_BIPOLAR_EN defined: all-ones -> +16; all-zeros -> -16 (6'b110000); 8 ones -> 0.

Source files
------------

// File: rtl/sc_matrix_decoder.sv
// sc_matrix_decoder: converts NUM_STREAMS stochastic bitstreams back into
// binary counts over a window of 2^LEN_LOG2 valid samples. All counts are
// presented together on a valid/ready output.
//
// Optional build macro: SC_DECODE_BIPOLAR_EN
//   undefined : out_data holds unsigned ones-counts, CW = LEN_LOG2+1
//   defined   : out_data holds 2*count - 2^LEN_LOG2 (two's complement),
//               CW = LEN_LOG2+2
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; samples are dropped
// ACCUM | counting ones on every valid sample; busy=1
// HOLD  | result held on out_data with out_valid=1 until handshake
module sc_matrix_decoder #(
  parameter int NUM_STREAMS = 16,
  parameter int LEN_LOG2    = 8,
`ifdef SC_DECODE_BIPOLAR_EN
  localparam int CW = LEN_LOG2 + 2
`else
  localparam int CW = LEN_LOG2 + 1
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      in_valid,
  input  logic [NUM_STREAMS-1:0]    streams_in,
  output logic                      busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_STREAMS*CW-1:0] out_data
);

  // Raw ones-count width; holds 0..2^LEN_LOG2 inclusive in either build.
  localparam int CNT_W = LEN_LOG2 + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [CNT_W-1:0]      cnt      [NUM_STREAMS];
  logic [CNT_W-1:0]      cnt_next [NUM_STREAMS];
  logic [LEN_LOG2-1:0]   samp_cnt;
  logic [NUM_STREAMS*CW-1:0] result;
  logic                  accept;
  logic                  last_sample;
  logic                  handshake;
  logic                  clear;

  assign accept      = (state == ACCUM) && in_valid;
  assign last_sample = accept && (samp_cnt == {LEN_LOG2{1'b1}});
  assign handshake   = (state == HOLD) && out_ready;
  // A new window opens from IDLE, or straight out of HOLD when the result
  // is taken on the same cycle start is seen (no IDLE bubble).
  assign clear       = ((state == IDLE) && start) || (handshake && start);

  assign busy      = (state == ACCUM);
  assign out_valid = (state == HOLD);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = ACCUM;
      end
      ACCUM: begin
        if (last_sample) state_next = HOLD;
      end
      HOLD: begin
        if (out_ready) state_next = start ? ACCUM : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Counts including the current sample, and their output encoding. The
  // final sample is folded in here so it lands in out_data on the same edge.
  always_comb begin
    result = '0;
    for (int k = 0; k < NUM_STREAMS; k++) begin
      cnt_next[k] = cnt[k] + CNT_W'(streams_in[k]);
`ifdef SC_DECODE_BIPOLAR_EN
      result[k*CW +: CW] = {cnt_next[k], 1'b0} - CW'(2**LEN_LOG2);
`else
      result[k*CW +: CW] = cnt_next[k];
`endif
    end
  end

  // Per-stream and sample counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp_cnt <= '0;
      for (int k = 0; k < NUM_STREAMS; k++) cnt[k] <= '0;
    end else if (clear) begin
      samp_cnt <= '0;
      for (int k = 0; k < NUM_STREAMS; k++) cnt[k] <= '0;
    end else if (accept) begin
      // Wraps to zero exactly on the last sample of the window.
      samp_cnt <= samp_cnt + LEN_LOG2'(1);
      for (int k = 0; k < NUM_STREAMS; k++) cnt[k] <= cnt_next[k];
    end
  end

  // Result register, loaded only at the window end and held through HOLD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data <= '0;
    end else if (last_sample) begin
      out_data <= result;
    end
  end

endmodule

// File: tb/tb_sc_matrix_decoder.sv
// tb_sc_matrix_decoder: directed test of sc_matrix_decoder with 4 streams
// and a 16-sample window. Honours SC_DECODE_BIPOLAR_EN for expected values.
module tb_sc_matrix_decoder;

  localparam int NS = 4;
  localparam int LL = 4;
`ifdef SC_DECODE_BIPOLAR_EN
  localparam int CW = LL + 2;
`else
  localparam int CW = LL + 1;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic            in_valid = 1'b0;
  logic [NS-1:0]   streams_in = '0;
  logic            busy;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [NS*CW-1:0] out_data;

  int tests = 0;
  int fails = 0;

  sc_matrix_decoder #(.NUM_STREAMS(NS), .LEN_LOG2(LL)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .streams_in (streams_in),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] conv(input int c);
`ifdef SC_DECODE_BIPOLAR_EN
    return CW'(2 * c - 16);
`else
    return CW'(c);
`endif
  endfunction

  function automatic logic [NS*CW-1:0] exp_word(input int c3, input int c2,
                                                input int c1, input int c0);
    return {conv(c3), conv(c2), conv(c1), conv(c0)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input logic [NS-1:0] s);
    in_valid   = 1'b1;
    streams_in = s;
    tick();
    in_valid   = 1'b0;
    streams_in = '0;
  endtask

  task automatic gap(input logic st);
    in_valid   = 1'b0;
    streams_in = 4'b1111;
    start      = st;
    tick();
    start      = 1'b0;
    streams_in = '0;
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [NS-1:0] pat;

    // Reset state
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    rst = 1'b1;
    tick();

    // 1: all ones, hold with out_ready low, then accept
    do_start();
    chk("t1_busy_after_start", 64'(busy), 64'(1));
    for (int i = 0; i < 15; i++) feed(4'b1111);
    chk("t1_no_early_valid", 64'(out_valid), 64'(0));
    feed(4'b1111);
    chk("t1_out_valid", 64'(out_valid), 64'(1));
    chk("t1_busy_low", 64'(busy), 64'(0));
    chk("t1_counts", 64'(out_data), 64'(exp_word(16, 16, 16, 16)));
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      in_valid = 1'b1;
      streams_in = 4'b0101;
      tick();
      start = 1'b0;
      in_valid = 1'b0;
      chk("t1_hold_valid", 64'(out_valid), 64'(1));
      chk("t1_hold_stable", 64'(out_data), 64'(exp_word(16, 16, 16, 16)));
    end
    take();
    chk("t1_valid_drop", 64'(out_valid), 64'(0));
    chk("t1_idle_busy", 64'(busy), 64'(0));

    // 2: mixed densities -> {16,4,8,0}
    do_start();
    for (int i = 0; i < 16; i++) begin
      pat = {1'b1, (i < 4), (i % 2 == 0), 1'b0};
      feed(pat);
    end
    chk("t2_valid", 64'(out_valid), 64'(1));
    chk("t2_counts", 64'(out_data), 64'(exp_word(16, 4, 8, 0)));
    take();

    // 3: same pattern with 10 stall cycles and spurious starts
    do_start();
    for (int i = 0; i < 16; i++) begin
      if (i >= 1 && i <= 10) gap(i % 3 == 0);
      if (i == 6) chk("t3_busy_in_gaps", 64'(busy), 64'(1));
      pat = {1'b1, (i < 4), (i % 2 == 0), 1'b0};
      feed(pat);
      if (i == 14) chk("t3_no_early_valid", 64'(out_valid), 64'(0));
    end
    chk("t3_valid", 64'(out_valid), 64'(1));
    chk("t3_counts", 64'(out_data), 64'(exp_word(16, 4, 8, 0)));

    // 4: handshake plus start -> straight into a new window of zeros
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    out_ready = 1'b0;
    chk("t4_busy_b2b", 64'(busy), 64'(1));
    chk("t4_valid_low", 64'(out_valid), 64'(0));
    for (int i = 0; i < 16; i++) feed(4'b0000);
    chk("t4_valid", 64'(out_valid), 64'(1));
    chk("t4_counts", 64'(out_data), 64'(exp_word(0, 0, 0, 0)));
    take();

    // 5: reset mid-window discards partial counts
    feed(4'b1111);  // dropped: arrives in IDLE
    do_start();
    for (int i = 0; i < 9; i++) feed(4'b1111);
    #2 rst = 1'b0;
    #1;
    chk("t5_rst_busy", 64'(busy), 64'(0));
    chk("t5_rst_valid", 64'(out_valid), 64'(0));
    chk("t5_rst_data", 64'(out_data), 64'(0));
    #3 rst = 1'b1;
    tick();
    chk("t5_idle_after_rst", 64'(busy), 64'(0));
    do_start();
    for (int i = 0; i < 15; i++) feed(4'b0000);
    chk("t5_no_early_valid", 64'(out_valid), 64'(0));
    feed(4'b0000);
    chk("t5_valid", 64'(out_valid), 64'(1));
    chk("t5_counts", 64'(out_data), 64'(exp_word(0, 0, 0, 0)));
    take();

    // 6: half-density window -> 8 (bipolar 0); in bipolar build check extremes
    do_start();
    for (int i = 0; i < 16; i++) feed((i < 8) ? 4'b1111 : 4'b0000);
    chk("t6_half_counts", 64'(out_data), 64'(exp_word(8, 8, 8, 8)));
`ifdef SC_DECODE_BIPOLAR_EN
    chk("t6_half_zero", 64'(out_data), 64'(0));
    take();
    do_start();
    for (int i = 0; i < 16; i++) feed(4'b0000);
    chk("t6_neg16", 64'(out_data), 64'({4{6'b110000}}));
    take();
    do_start();
    for (int i = 0; i < 16; i++) feed(4'b1111);
    chk("t6_pos16", 64'(out_data), 64'({4{6'b010000}}));
`endif
    take();
    chk("t6_final_idle", 64'(out_valid), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
